// File: rtl/spi_frame_rx.sv
// rtl/spi_frame_rx.sv - oversampled SPI slave frame receiver with status word shift-out
module spi_frame_rx #(
  parameter int BIT_WIDTH = 160,
  parameter int TX_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sck,
  input  logic                 ssel,
  input  logic                 mosi,
  output logic                 miso,
  input  logic [TX_WIDTH-1:0]  tx_data,
  output logic [BIT_WIDTH-1:0] rx_data,
  output logic                 rx_data_tick,
  output logic                 frame_err
);

  localparam int CW = $clog2(BIT_WIDTH + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(BIT_WIDTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(BIT_WIDTH + 1);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;

  // [0],[1] synchronize, [2] is the history flop used for edge detection
  logic [2:0] sck_sr, ssel_sr, mosi_sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sr  <= '0;
      ssel_sr <= '0;
      mosi_sr <= '0;
    end else begin
      sck_sr  <= {sck_sr[1:0], sck};
      ssel_sr <= {ssel_sr[1:0], ssel};
      mosi_sr <= {mosi_sr[1:0], mosi};
    end
  end

  logic sck_fall, sck_rise, ssel_fall, ssel_rise, ssel_s, mosi_bit;
  assign sck_fall  = sck_sr[2] & ~sck_sr[1];
  assign sck_rise  = ~sck_sr[2] & sck_sr[1];
  assign ssel_fall = ssel_sr[2] & ~ssel_sr[1];
  assign ssel_rise = ~ssel_sr[2] & ssel_sr[1];
  assign ssel_s    = ssel_sr[1];
  // mosi is stable around the sck edge, so the history stage gives the pre-edge value
  assign mosi_bit  = mosi_sr[2];

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [BIT_WIDTH-1:0] rx_sh;
  logic [TX_WIDTH-1:0]  tx_sh;
  logic [TX_WIDTH-1:0]  tx_shl;

  assign tx_shl = tx_sh << 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= WAIT_IDLE;
      cnt          <= '0;
      rx_sh        <= '0;
      tx_sh        <= '0;
      rx_data      <= '0;
      miso         <= 1'b0;
      rx_data_tick <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      rx_data_tick <= 1'b0;
      frame_err    <= 1'b0;
      case (state)
        WAIT_IDLE: begin
          if (ssel_s) state <= IDLE;
        end
        IDLE: begin
          if (ssel_fall) begin
            state <= ACTIVE;
            cnt   <= '0;
            tx_sh <= tx_data;
            miso  <= tx_data[TX_WIDTH-1];
          end
        end
        ACTIVE: begin
          // end of frame takes priority over any coincident sck edge
          if (ssel_rise) begin
            state <= IDLE;
            miso  <= 1'b0;
            if (cnt == CNT_FULL) begin
              rx_data      <= rx_sh;
              rx_data_tick <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else if (sck_fall) begin
            rx_sh <= {rx_sh[BIT_WIDTH-2:0], mosi_bit};
            if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
          end else if (sck_rise && cnt != '0) begin
            tx_sh <= tx_shl;
            miso  <= tx_shl[TX_WIDTH-1];
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_rx.sv
// tb/tb_spi_frame_rx.sv - scoreboard bench for spi_frame_rx driven by a bit-level SPI master model
module tb_spi_frame_rx;
  localparam int BW  = 160;
  localparam int TXW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sck = 1'b1;
  logic          ssel = 1'b1;
  logic          mosi = 1'b0;
  logic          miso;
  logic [TXW-1:0] tx_data = '0;
  logic [BW-1:0] rx_data;
  logic          rx_data_tick;
  logic          frame_err;

  spi_frame_rx #(.BIT_WIDTH(BW), .TX_WIDTH(TXW)) dut (
    .clk(clk), .rst(rst), .sck(sck), .ssel(ssel), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .rx_data(rx_data), .rx_data_tick(rx_data_tick), .frame_err(frame_err)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic          is_err;
    logic [BW-1:0] data;
  } ev_t;

  ev_t           exp_q[$];
  logic [BW-1:0] last_good = '0;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every output pulse is matched against the next expected event
  logic prev_pulse = 1'b0;
  always @(negedge clk) begin
    ev_t e;
    if (rst) begin
      prev_pulse = 1'b0;
    end else if (rx_data_tick || frame_err) begin
      chk("pulse_exclusive", BW'(rx_data_tick & frame_err), '0);
      chk("pulse_not_back_to_back", BW'(prev_pulse), '0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got tick=%0b err=%0b expected none", rx_data_tick, frame_err);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind_err", BW'(frame_err), BW'(e.is_err));
        chk("rx_data_at_pulse", rx_data, e.data);
      end
      prev_pulse = 1'b1;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  // SPI master: mosi set while sck high, both sides sample on sck falling edge
  task automatic send_frame(input logic [BW-1:0] data, input int nbits, input logic [TXW-1:0] tx,
                            input int ph, input int gap, input int abort_at);
    logic aborted;
    logic b;
    ev_t  e;
    aborted = 1'b0;
    @(negedge clk);
    tx_data = tx;
    ssel    = 1'b0;
    mosi    = (nbits > 0) ? data[BW-1] : 1'b0;
    repeat (ph) @(negedge clk);
    tx_data = TXW'($urandom);
    for (int i = 0; i < nbits; i++) begin
      sck = 1'b0;
      if (!aborted)
        chk("miso_bit", BW'(miso), (i < TXW) ? BW'(tx[TXW-1-i]) : '0);
      repeat (ph) @(negedge clk);
      sck = 1'b1;
      b = (i + 1 < BW) ? data[BW-2-i] : 1'($urandom);
      mosi = b;
      repeat (ph) @(negedge clk);
      if (abort_at > 0 && i + 1 == abort_at) begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        aborted = 1'b1;
        last_good = '0;
        chk("rx_data_after_reset", rx_data, '0);
        chk("miso_after_reset", BW'(miso), '0);
      end
    end
    if (!aborted) begin
      if (nbits == BW) begin
        last_good = data;
        e.is_err = 1'b0;
      end else begin
        e.is_err = 1'b1;
      end
      e.data = last_good;
      exp_q.push_back(e);
    end
    ssel = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  logic [BW-1:0] d;
  int            len;

  initial begin
    repeat (4) @(negedge clk);
    chk("reset_rx_data", rx_data, '0);
    chk("reset_miso", BW'(miso), '0);
    chk("reset_tick", BW'(rx_data_tick), '0);
    chk("reset_err", BW'(frame_err), '0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    d = '0;
    for (int k = 0; k < 10; k++) d = {d[BW-17:0], 16'(k + 1)};
    send_frame(d, BW, 16'hA5C3, 5, 10, 0);
    chk("word_hi", BW'(rx_data[159:144]), BW'(16'h0001));
    chk("word_lo", BW'(rx_data[15:0]), BW'(16'h000A));

    send_frame({BW{1'b1}}, BW, 16'h0F0F, 5, 10, 0);
    send_frame('0, BW - 1, 16'h1234, 5, 10, 0);
    send_frame('0, BW + 1, 16'h8001, 5, 10, 0);
    chk("rx_data_kept_ones", rx_data, {BW{1'b1}});

    send_frame('0, 0, 16'h0000, 5, 10, 0);
    for (int k = 0; k < 10; k++) begin
      sck = 1'b0;
      repeat (5) @(negedge clk);
      sck = 1'b1;
      repeat (5) @(negedge clk);
    end
    chk("idle_miso", BW'(miso), '0);

    send_frame({BW{1'b1}}, BW, 16'hFFFF, 5, 10, 80);
    chk("rx_data_zero_after_abort", rx_data, '0);
    send_frame({10{16'h1234}}, BW, 16'h5A5A, 5, 10, 0);
    chk("rx_data_1234", rx_data, {10{16'h1234}});

    send_frame({5{32'hDEADBEEF}}, BW, 16'hC001, 4, 4, 0);
    send_frame({5{32'h13579BDF}}, BW, 16'h2468, 4, 4, 0);

    for (int r = 0; r < 8; r++) begin
      for (int w = 0; w < BW / 32; w++) d = {d[BW-33:0], 32'($urandom)};
      case ($urandom_range(0, 3))
        0: len = BW - 1 - $urandom_range(0, 3);
        1: len = BW + 1 + $urandom_range(0, 2);
        default: len = BW;
      endcase
      send_frame(d, len, TXW'($urandom), $urandom_range(4, 6), $urandom_range(4, 8), 0);
    end

    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
    chk("queue_drained", BW'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
